// File: rtl/interrupt_sequencer_pkg.sv
// Shared types and default vectors/lengths for the interrupt sequencer slice.
package norz_int_pkg;

  localparam logic [15:0] NMI_VEC_DEF = 16'h0066;
  localparam logic [15:0] IM1_VEC_DEF = 16'h0038;
  localparam int          RST_LEN_DEF = 3;
  localparam int          ACK_LEN_DEF = 6;
  localparam int          NMI_LEN_DEF = 5;
  localparam int          CNT_W       = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_NMI,
    S_INT,
    S_DONE
  } seq_state_t;

  typedef enum logic [1:0] {
    K_RESTART = 2'd0,
    K_IM0     = 2'd1,
    K_IM2     = 2'd2
  } vec_kind_t;

  // Sequence entry requested on the current edge; drives the IFF file overrides.
  typedef enum logic [1:0] {
    OP_NONE,
    OP_RST,
    OP_NMI,
    OP_INT
  } seq_op_t;

  typedef struct packed {
    vec_kind_t   kind;
    logic [15:0] pc;
  } vec_t;

  function automatic vec_t int_vector(input logic [1:0]  imode,
                                      input logic [7:0]  ireg,
                                      input logic [7:0]  data,
                                      input logic [15:0] im1_vec);
    vec_t v;
    case (imode)
      2'd1:    v = '{kind: K_RESTART, pc: im1_vec};
      2'd2:    v = '{kind: K_IM2,     pc: {ireg, data[7:1], 1'b0}};
      default: v = '{kind: K_IM0,     pc: {8'h00, data}};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/interrupt_sequencer_iff_unit.sv
// IFF1/IFF2, EI shadow and interrupt mode; sequence overrides beat decoder strobes.
module int_iff_unit
  import norz_int_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_end,
  input  logic       dec_ei,
  input  logic       dec_di,
  input  logic       dec_retn,
  input  logic       dec_im_wr,
  input  logic [1:0] dec_im,
  input  seq_op_t    seq_op,
  output logic       iff1,
  output logic       iff2,
  output logic [1:0] imode,
  output logic       int_block
);

  logic shadow;

  always_ff @(posedge clk) begin
    if (reset) begin
      iff1   <= 1'b0;
      iff2   <= 1'b0;
      imode  <= 2'd0;
      shadow <= 1'b0;
    end else begin
      if (instr_end) begin
        shadow <= dec_ei;
        if (dec_di) begin
          iff1 <= 1'b0;
          iff2 <= 1'b0;
        end else if (dec_ei) begin
          iff1 <= 1'b1;
          iff2 <= 1'b1;
        end else if (dec_retn) begin
          iff1 <= iff2;
        end
        if (dec_im_wr && dec_im != 2'd3) imode <= dec_im;
      end
      // Placed last so a sequence entry overrides a same-cycle decoder write.
      case (seq_op)
        OP_RST: begin
          iff1   <= 1'b0;
          iff2   <= 1'b0;
          imode  <= 2'd0;
          shadow <= 1'b0;
        end
        OP_NMI: begin
          iff1 <= 1'b0;
          iff2 <= iff1;
        end
        OP_INT: begin
          iff1 <= 1'b0;
          iff2 <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // The EI itself and any boundary before the following instruction retires are blocked.
  assign int_block = (instr_end & dec_ei) | (shadow & ~instr_end);

endmodule

// File: rtl/interrupt_sequencer.sv
// Arbitrates latched reset/NMI/INT requests at instruction boundaries and steps the
// chosen special sequence, issuing clear strobes and the restart vector.
module interrupt_sequencer
  import norz_int_pkg::*;
#(
  parameter logic [15:0] NMI_VEC = NMI_VEC_DEF,
  parameter logic [15:0] IM1_VEC = IM1_VEC_DEF,
  parameter int          RST_LEN = RST_LEN_DEF,
  parameter int          ACK_LEN = ACK_LEN_DEF,
  parameter int          NMI_LEN = NMI_LEN_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        TRESET,
  input  logic        TNMI,
  input  logic        TINT,
  input  logic        TWAIT,
  input  logic        InstrEnd,
  input  logic        Halted,
  input  logic        DecEI,
  input  logic        DecDI,
  input  logic        DecRETN,
  input  logic [1:0]  DecIM,
  input  logic        DecIMWr,
  input  logic [7:0]  IReg,
  input  logic [7:0]  DataIn,
  output logic        notIFF1,
  output logic        IFF2,
  output logic [1:0]  IMode,
  output logic        P2_Reset_TINT,
  output logic        P2_Reset_TNMI,
  output logic        P2_Reset_ALLUNOFFICIALFF,
  output logic        SeqBusy,
  output logic        IntAckCyc,
  output logic        SeqDone,
  output logic [1:0]  VecKind,
  output logic [15:0] VecPC
);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_LEN - 1);
  localparam logic [CNT_W-1:0] NMI_LAST   = CNT_W'(NMI_LEN - 1);
  localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_LEN - 1);
  localparam logic [CNT_W-1:0] ACK_SAMPLE = CNT_W'(ACK_LEN - 2);

  seq_state_t       state;
  logic [CNT_W-1:0] cnt;
  seq_op_t          seq_op;
  vec_t             vec;
  logic             iff1;
  logic             int_block;
  logic             advance;
  logic             p2_all, p2_nmi, p2_int;

  int_iff_unit u_iff (
    .clk       (Clk),
    .reset     (Reset),
    .instr_end (InstrEnd),
    .dec_ei    (DecEI),
    .dec_di    (DecDI),
    .dec_retn  (DecRETN),
    .dec_im_wr (DecIMWr),
    .dec_im    (DecIM),
    .seq_op    (seq_op),
    .iff1      (iff1),
    .iff2      (IFF2),
    .imode     (IMode),
    .int_block (int_block)
  );

  // Entry decision: boundary arbitration in IDLE, or reset abort of an ack sequence.
  always_comb begin
    seq_op = OP_NONE;
    if ((state == S_NMI || state == S_INT) && TRESET) begin
      seq_op = OP_RST;
    end else if (state == S_IDLE && (InstrEnd || Halted)) begin
      if (TRESET)                             seq_op = OP_RST;
      else if (TNMI)                          seq_op = OP_NMI;
      else if (TINT && iff1 && !int_block)    seq_op = OP_INT;
    end
  end

  // Cycle 0 always advances so the entry strobe cannot repeat under a wait.
  assign advance = (cnt == '0) || !TWAIT;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      p2_all <= 1'b0;
      p2_nmi <= 1'b0;
      p2_int <= 1'b0;
      vec    <= '{kind: K_RESTART, pc: 16'h0000};
    end else begin
      p2_all <= 1'b0;
      p2_nmi <= 1'b0;
      p2_int <= 1'b0;
      case (seq_op)
        OP_RST: begin
          state  <= S_RST;
          cnt    <= '0;
          p2_all <= 1'b1;
          vec    <= '{kind: K_RESTART, pc: 16'h0000};
        end
        OP_NMI: begin
          state  <= S_NMI;
          cnt    <= '0;
          p2_nmi <= 1'b1;
          vec    <= '{kind: K_RESTART, pc: NMI_VEC};
        end
        OP_INT: begin
          state  <= S_INT;
          cnt    <= '0;
          p2_int <= 1'b1;
        end
        default: begin
          case (state)
            S_RST: begin
              if (cnt == RST_LAST) state <= S_DONE;
              else                 cnt   <= cnt + CNT_ONE;
            end
            S_NMI: begin
              if (advance) begin
                if (cnt == NMI_LAST) state <= S_DONE;
                else                 cnt   <= cnt + CNT_ONE;
              end
            end
            S_INT: begin
              if (cnt == ACK_SAMPLE) vec <= int_vector(IMode, IReg, DataIn, IM1_VEC);
              if (advance) begin
                if (cnt == ACK_LAST) state <= S_DONE;
                else                 cnt   <= cnt + CNT_ONE;
              end
            end
            S_DONE: begin
              state <= S_IDLE;
              cnt   <= '0;
            end
            default: state <= S_IDLE;
          endcase
        end
      endcase
    end
  end

  assign notIFF1                  = ~iff1;
  assign P2_Reset_TINT            = p2_int;
  assign P2_Reset_TNMI            = p2_nmi;
  assign P2_Reset_ALLUNOFFICIALFF = p2_all;
  assign SeqBusy                  = (state != S_IDLE);
  assign SeqDone                  = (state == S_DONE);
  assign IntAckCyc                = (state == S_INT) && (cnt >= CNT_ONE) && (cnt <= ACK_SAMPLE);
  assign VecKind                  = vec.kind;
  assign VecPC                    = vec.pc;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed and randomized bench for interrupt_sequencer against a cycle-count model.
module tb_interrupt_sequencer;

  localparam int RST_LEN = 3;
  localparam int ACK_LEN = 6;
  localparam int NMI_LEN = 5;
  localparam int SQ_NONE = 0, SQ_RST = 1, SQ_NMI = 2, SQ_INT = 3;

  logic        Clk = 1'b0;
  logic        Reset, TRESET, TNMI, TINT, TWAIT, InstrEnd, Halted;
  logic        DecEI, DecDI, DecRETN, DecIMWr;
  logic [1:0]  DecIM;
  logic [7:0]  IReg, DataIn;
  logic        notIFF1, IFF2, P2_Reset_TINT, P2_Reset_TNMI, P2_Reset_ALLUNOFFICIALFF;
  logic        SeqBusy, IntAckCyc, SeqDone;
  logic [1:0]  IMode, VecKind;
  logic [15:0] VecPC;

  int checks = 0;
  int failures = 0;

  logic       m_iff1, m_iff2;
  logic [1:0] m_im;

  int          r_busy, r_all, r_nmi, r_int, r_ack;
  logic        r_done;
  logic [15:0] r_vec;
  logic [1:0]  r_kind;

  interrupt_sequencer dut (
    .Clk(Clk), .Reset(Reset), .TRESET(TRESET), .TNMI(TNMI), .TINT(TINT), .TWAIT(TWAIT),
    .InstrEnd(InstrEnd), .Halted(Halted), .DecEI(DecEI), .DecDI(DecDI), .DecRETN(DecRETN),
    .DecIM(DecIM), .DecIMWr(DecIMWr), .IReg(IReg), .DataIn(DataIn),
    .notIFF1(notIFF1), .IFF2(IFF2), .IMode(IMode), .P2_Reset_TINT(P2_Reset_TINT),
    .P2_Reset_TNMI(P2_Reset_TNMI), .P2_Reset_ALLUNOFFICIALFF(P2_Reset_ALLUNOFFICIALFF),
    .SeqBusy(SeqBusy), .IntAckCyc(IntAckCyc), .SeqDone(SeqDone), .VecKind(VecKind),
    .VecPC(VecPC)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_iff(input string tag);
    chk({tag, ".iff1"},  32'(!notIFF1), 32'(m_iff1));
    chk({tag, ".iff2"},  32'(IFF2),     32'(m_iff2));
    chk({tag, ".imode"}, 32'(IMode),    32'(m_im));
  endtask

  // One boundary cycle; the model applies decoder rules then any expected sequence entry.
  task automatic instr(input logic ei, input logic di, input logic retn, input logic imwr,
                       input logic [1:0] im, input int seq, input logic halt);
    logic pre;
    pre      = m_iff1;
    InstrEnd = !halt;
    Halted   = halt;
    DecEI    = ei;
    DecDI    = di;
    DecRETN  = retn;
    DecIMWr  = imwr;
    DecIM    = im;
    if (!halt) begin
      if (di)        begin m_iff1 = 1'b0; m_iff2 = 1'b0; end
      else if (ei)   begin m_iff1 = 1'b1; m_iff2 = 1'b1; end
      else if (retn) m_iff1 = m_iff2;
      if (imwr && im != 2'd3) m_im = im;
    end
    case (seq)
      SQ_RST:  begin m_iff1 = 1'b0; m_iff2 = 1'b0; m_im = 2'd0; end
      SQ_NMI:  begin m_iff2 = pre;  m_iff1 = 1'b0; end
      SQ_INT:  begin m_iff1 = 1'b0; m_iff2 = 1'b0; end
      default: ;
    endcase
    tick();
    InstrEnd = 1'b0; Halted = 1'b0; DecEI = 1'b0; DecDI = 1'b0;
    DecRETN = 1'b0; DecIMWr = 1'b0; DecIM = 2'd0;
  endtask

  // Observes from the first sequence cycle until SeqDone, acting as the request flops.
  task automatic run_seq(input int wait_at, input int wait_len, input int rst_at,
                         input int data0, input int data_step);
    r_busy = 0; r_all = 0; r_nmi = 0; r_int = 0; r_ack = 0; r_done = 1'b0;
    r_vec = 16'hxxxx; r_kind = 2'bxx;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (SeqDone) begin
        r_done = 1'b1;
        r_vec  = VecPC;
        r_kind = VecKind;
        break;
      end
      if (SeqBusy) r_busy++;
      if (IntAckCyc) r_ack++;
      if (P2_Reset_ALLUNOFFICIALFF) begin r_all++; TRESET = 1'b0; TNMI = 1'b0; TINT = 1'b0; end
      if (P2_Reset_TNMI) begin r_nmi++; TNMI = 1'b0; end
      if (P2_Reset_TINT) begin r_int++; TINT = 1'b0; end
      if (cyc == rst_at) TRESET = 1'b1;
      TWAIT  = (cyc >= wait_at) && (cyc < wait_at + wait_len);
      DataIn = 8'(data0 + data_step * cyc);
      tick();
    end
    TWAIT = 1'b0;
  endtask

  initial begin
    logic [1:0]  im;
    logic [7:0]  smp;
    logic [15:0] e_vec;
    logic [1:0]  e_kind;
    int          wait_at, wait_len, d0, step;
    logic        halt;

    Reset = 1'b1; TRESET = 1'b0; TNMI = 1'b0; TINT = 1'b0; TWAIT = 1'b0;
    InstrEnd = 1'b0; Halted = 1'b0; DecEI = 1'b0; DecDI = 1'b0; DecRETN = 1'b0;
    DecIMWr = 1'b0; DecIM = 2'd0; IReg = 8'h00; DataIn = 8'h00;
    m_iff1 = 1'b0; m_iff2 = 1'b0; m_im = 2'd0;
    tick();
    Reset = 1'b0;

    chk_iff("reset");
    chk("reset.busy", 32'(SeqBusy), 32'd0);
    chk("reset.done", 32'(SeqDone), 32'd0);
    chk("reset.ack", 32'(IntAckCyc), 32'd0);
    chk("reset.strobes", 32'({P2_Reset_ALLUNOFFICIALFF, P2_Reset_TNMI, P2_Reset_TINT}), 32'd0);

    instr(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, SQ_NONE, 1'b0);
    chk("idle.no_req", 32'(SeqBusy), 32'd0);

    // Reset sequence
    TRESET = 1'b1;
    instr(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, SQ_RST, 1'b0);
    run_seq(-1, 0, -1, 0, 0);
    chk("rst.busy", 32'(r_busy), 32'(RST_LEN));
    chk("rst.done", 32'(r_done), 32'd1);
    chk("rst.allunoff", 32'(r_all), 32'd1);
    chk("rst.other_strobes", 32'(r_nmi + r_int), 32'd0);
    chk("rst.vec", 32'(r_vec), 32'h0000);
    chk("rst.kind", 32'(r_kind), 32'd0);
    tick();
    chk("rst.idle", 32'(SeqBusy), 32'd0);
    chk_iff("rst");

    // IM2 ack after EI shadow
    instr(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, SQ_NONE, 1'b0);
    chk_iff("im2");
    TINT = 1'b1;
    instr(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, SQ_NONE, 1'b0);
    chk("ei.not_taken", 32'(SeqBusy), 32'd0);
    chk_iff("ei");
    IReg = 8'h12;
    instr(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, SQ_INT, 1'b0);
    run_seq(-1, 0, -1, 8'h35, 0);
    chk("im2.busy", 32'(r_busy), 32'(ACK_LEN));
    chk("im2.done", 32'(r_done), 32'd1);
    chk("im2.tint_clr", 32'(r_int), 32'd1);
    chk("im2.ackcyc", 32'(r_ack), 32'(ACK_LEN - 2));
    chk("im2.kind", 32'(r_kind), 32'd2);
    chk("im2.vec", 32'(r_vec), 32'h1234);
    chk_iff("im2.ack");
    tick();

    // Randomized INT acks: mode, wait placement, bus data, boundary kind
    for (int i = 0; i < 6; i++) begin
      im       = 2'($urandom_range(0, 2));
      wait_at  = int'($urandom_range(1, 4));
      wait_len = int'($urandom_range(0, 3));
      d0       = int'($urandom_range(0, 255));
      step     = int'($urandom_range(1, 255));
      halt     = 1'($urandom_range(0, 1));
      IReg     = 8'($urandom);
      instr(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, SQ_NONE, 1'b0);
      chk_iff("rnd.im3_ignored");
      instr(1'b0, 1'b0, 1'b0, 1'b1, im, SQ_NONE, 1'b0);
      instr(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, SQ_NONE, 1'b0);
      instr(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, SQ_NONE, 1'b0);
      TINT = 1'b1;
      instr(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, SQ_INT, halt);
      run_seq(wait_at, wait_len, -1, d0, step);
      smp = 8'(d0 + step * (ACK_LEN - 2 + wait_len));
      case (im)
        2'd1:    begin e_vec = 16'h0038;                e_kind = 2'd0; end
        2'd2:    begin e_vec = {IReg, smp[7:1], 1'b0};  e_kind = 2'd2; end
        default: begin e_vec = {8'h00, smp};            e_kind = 2'd1; end
      endcase
      chk("rnd.busy", 32'(r_busy), 32'(ACK_LEN + wait_len));
      chk("rnd.ackcyc", 32'(r_ack), 32'(ACK_LEN - 2 + wait_len));
      chk("rnd.tint_clr", 32'(r_int), 32'd1);
      chk("rnd.vec", 32'(r_vec), 32'(e_vec));
      chk("rnd.kind", 32'(r_kind), 32'(e_kind));
      chk_iff("rnd.ack");
      tick();
    end

    // NMI with IFF1 set and a 3-cycle wait, then RETN
    instr(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, SQ_NONE, 1'b0);
    instr(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, SQ_NONE, 1'b0);
    TNMI = 1'b1;
    instr(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, SQ_NMI, 1'b0);
    run_seq(2, 3, -1, 0, 0);
    chk("nmi.busy", 32'(r_busy), 32'(NMI_LEN + 3));
    chk("nmi.tnmi_clr", 32'(r_nmi), 32'd1);
    chk("nmi.tint_clr", 32'(r_int), 32'd0);
    chk("nmi.vec", 32'(r_vec), 32'h0066);
    chk("nmi.kind", 32'(r_kind), 32'd0);
    chk_iff("nmi");
    tick();
    instr(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, SQ_NONE, 1'b0);
    chk_iff("retn");

    // INT blocked at an EI boundary even with IFF1 already set
    TINT = 1'b1;
    instr(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, SQ_NONE, 1'b0);
    chk("ei_shadow.not_taken", 32'(SeqBusy), 32'd0);
    TINT = 1'b0;

    // NMI entry beats a same-cycle DI
    TNMI = 1'b1;
    instr(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, SQ_NMI, 1'b0);
    run_seq(-1, 0, -1, 0, 0);
    chk("nmi_di.busy", 32'(r_busy), 32'(NMI_LEN));
    chk_iff("nmi_di");
    tick();

    // Reset arriving in INT ack cycle 3 aborts into the reset sequence
    instr(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, SQ_NONE, 1'b0);
    instr(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, SQ_NONE, 1'b0);
    TINT = 1'b1;
    instr(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, SQ_INT, 1'b0);
    run_seq(-1, 0, 3, 8'h77, 0);
    m_iff1 = 1'b0; m_iff2 = 1'b0; m_im = 2'd0;
    chk("abort.busy", 32'(r_busy), 32'(4 + RST_LEN));
    chk("abort.allunoff", 32'(r_all), 32'd1);
    chk("abort.tint_clr", 32'(r_int), 32'd1);
    chk("abort.vec", 32'(r_vec), 32'h0000);
    chk("abort.kind", 32'(r_kind), 32'd0);
    chk_iff("abort");
    tick();

    // NMI raised during an INT ack waits for the next boundary
    instr(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, SQ_NONE, 1'b0);
    TINT = 1'b1;
    instr(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, SQ_INT, 1'b0);
    TNMI = 1'b1;
    run_seq(-1, 0, -1, 8'h44, 0);
    chk("int_nmi.done", 32'(r_done), 32'd1);
    chk("int_nmi.no_tnmi", 32'(r_nmi), 32'd0);
    chk("int_nmi.vec", 32'(r_vec), 32'h0044);
    chk("int_nmi.kind", 32'(r_kind), 32'd1);
    tick();
    chk("int_nmi.idle", 32'(SeqBusy), 32'd0);
    instr(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, SQ_NMI, 1'b0);
    run_seq(-1, 0, -1, 0, 0);
    chk("int_nmi.nmi_busy", 32'(r_busy), 32'(NMI_LEN));
    chk("int_nmi.tnmi_clr", 32'(r_nmi), 32'd1);
    chk("int_nmi.nmi_vec", 32'(r_vec), 32'h0066);
    chk_iff("int_nmi");
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
